// File: rtl/button_pulse_gen_pkg.sv
// Shared constants and types for the push-button conditioning block.
package button_pulse_gen_pkg;

    // Bit positions of each button in the btn_level vector and internal buses.
    localparam int BTN_SEL  = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;
    localparam int NUM_BTN  = 3;

    // Default timing for a 50 MHz system clock.
    localparam int CLK_HZ             = 50_000_000;
    localparam int DEF_DEB_CYCLES     = CLK_HZ / 100;   // 10 ms
    localparam int DEF_HOLD_CYCLES    = CLK_HZ / 2;     // 0.5 s
    localparam int DEF_REPEAT_CYCLES  = CLK_HZ / 10;    // 0.1 s

    // Counter width needed to hold the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return $clog2(m + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DEB_CYCLES, DEF_HOLD_CYCLES, DEF_REPEAT_CYCLES);

    // Auto-repeat phase of an UP/DOWN channel.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/button_pulse_gen_btn_debounce.sv
// One button: 2-flop synchronizer, counter debouncer, rising-edge event.
// The debounced level flips on the cycle after the counter has observed
// DEB_CYCLES consecutive cycles of disagreement with the synchronized input.
module btn_debounce
    import button_pulse_gen_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter: count disagreement cycles, flip level once stable long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
            r_level <= r_level;
        end else if (r_cnt == DEB_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_level <= r_level;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/button_pulse_gen.sv
// Conditions SEL/UP/DOWN buttons into arbitrated single-cycle pulses,
// with hold-to-repeat on UP and DOWN.
module button_pulse_gen
    import button_pulse_gen_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sel,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       sel_pulse,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [2:0] btn_level
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_db;
    logic [NUM_BTN-1:0] w_rise;

    // Repeat channels: index 0 = UP, index 1 = DOWN.
    logic [1:0] w_rep_db;
    logic [1:0] w_rep_rise;
    logic [1:0] w_rep_evt;
    logic       w_conflict;

    logic w_sel_evt;
    logic w_up_evt;
    logic w_down_evt;

    logic r_sel_pulse;
    logic r_up_pulse;
    logic r_down_pulse;

    assign w_raw[BTN_SEL]  = btn_sel;
    assign w_raw[BTN_UP]   = btn_up;
    assign w_raw[BTN_DOWN] = btn_down;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .i_btn_raw (w_raw[g]),
            .o_level   (w_db[g]),
            .o_rise    (w_rise[g])
        );
    end

    assign w_rep_db   = {w_db[BTN_DOWN], w_db[BTN_UP]};
    assign w_rep_rise = {w_rise[BTN_DOWN], w_rise[BTN_UP]};
    // Both directions held at once: freeze repeat timing on both.
    assign w_conflict = w_db[BTN_UP] & w_db[BTN_DOWN];

    for (genvar g = 0; g < 2; g++) begin : g_rep
        rpt_state_e       r_state;
        rpt_state_e       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_evt;

        // Repeat phase and timer registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= RPT_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Repeat next-state logic; release always wins, conflict parks in HOLD at 0.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_evt       = 1'b0;
            case (r_state)
                RPT_IDLE: begin
                    if (w_rep_rise[g]) begin
                        w_state_nxt = RPT_HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = RPT_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                RPT_HOLD: begin
                    if (!w_rep_db[g]) begin
                        w_state_nxt = RPT_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_conflict) begin
                        w_state_nxt = RPT_HOLD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_evt       = 1'b1;
                        w_state_nxt = RPT_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = RPT_HOLD;
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                RPT_REPEAT: begin
                    if (!w_rep_db[g]) begin
                        w_state_nxt = RPT_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_conflict) begin
                        w_state_nxt = RPT_HOLD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == REP_LAST) begin
                        w_evt       = 1'b1;
                        w_state_nxt = RPT_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = RPT_REPEAT;
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = RPT_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_rep_evt[g] = w_evt;
    end

    assign w_sel_evt  = w_rise[BTN_SEL];
    assign w_up_evt   = w_rise[BTN_UP] | w_rep_evt[0];
    assign w_down_evt = w_rise[BTN_DOWN] | w_rep_evt[1];

    // Fixed-priority output stage (sel > up > down); losers are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_pulse  <= 1'b0;
            r_up_pulse   <= 1'b0;
            r_down_pulse <= 1'b0;
        end else begin
            r_sel_pulse  <= w_sel_evt;
            r_up_pulse   <= w_up_evt & ~w_sel_evt;
            r_down_pulse <= w_down_evt & ~w_sel_evt & ~w_up_evt;
        end
    end

    assign sel_pulse  = r_sel_pulse;
    assign up_pulse   = r_up_pulse;
    assign down_pulse = r_down_pulse;
    assign btn_level  = {w_db[BTN_DOWN], w_db[BTN_UP], w_db[BTN_SEL]};

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench for button_pulse_gen with short timing parameters.
module tb_button_pulse_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int CW   = 8;
    // Pulse for a press driven just before edge 0 appears after edge 3+DEB.
    localparam int LAT  = 1 + 3 + DEB;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_sel  = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       sel_pulse;
    logic       up_pulse;
    logic       down_pulse;
    logic [2:0] btn_level;

    button_pulse_gen #(
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_sel    (btn_sel),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .sel_pulse  (sel_pulse),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .btn_level  (btn_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   base;

    task automatic expect_pulse(input int at, input int ch);
        exp_t e;
        e.cyc = at;
        e.ch  = ch;
        exp_q.push_back(e);
    endtask

    task automatic check_level(input string name, input logic [2:0] want);
        total++;
        if (btn_level !== want) begin
            bad++;
            $display("FAIL %s: btn_level got %b want %b (cyc %0d)", name, btn_level, want, cyc);
        end
    endtask

    task automatic check_quiet(input string name);
        total++;
        if ({down_pulse, up_pulse, sel_pulse} !== 3'b000) begin
            bad++;
            $display("FAIL %s: pulses got %b want 000", name, {down_pulse, up_pulse, sel_pulse});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Monitor: every output pulse must match the head of the scoreboard.
        fork
            begin
                logic [2:0] p;
                int         ch;
                exp_t       e;
                forever begin
                    @(negedge clk);
                    p = {down_pulse, up_pulse, sel_pulse};
                    if (p != 3'b000) begin
                        total++;
                        ch = p[0] ? 0 : (p[1] ? 1 : 2);
                        if ($countones(p) != 1) begin
                            bad++;
                            $display("FAIL onehot: pulses got %b want one-hot (cyc %0d)", p, cyc);
                        end else if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected: channel %0d pulse at cyc %0d, none expected", ch, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.ch != ch) begin
                                bad++;
                                $display("FAIL pulse: got ch %0d at cyc %0d want ch %0d at cyc %0d",
                                         ch, cyc, e.ch, e.cyc);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state.
        idle(3);
        check_level("reset_level", 3'b000);
        check_quiet("reset_pulses");
        rst = 1'b0;
        idle(5);

        // Short glitch on UP is discarded.
        btn_up = 1'b1;
        idle(3);
        btn_up = 1'b0;
        idle(20);
        check_level("glitch_level", 3'b000);

        // SEL press: one pulse, level rises after edge 2+DEB, no repeat.
        base = cyc;
        btn_sel = 1'b1;
        expect_pulse(base + LAT, 0);
        idle(6);
        check_level("sel_lvl_pre", 3'b000);
        idle(1);
        check_level("sel_lvl_post", 3'b001);
        idle(23);
        btn_sel = 1'b0;
        idle(20);
        check_level("sel_released", 3'b000);

        // UP held 60 cycles: press plus five auto-repeats.
        base = cyc;
        btn_up = 1'b1;
        expect_pulse(base + LAT, 1);
        expect_pulse(base + LAT + HOLD, 1);
        for (int k = 1; k <= 4; k++) begin
            expect_pulse(base + LAT + HOLD + k * REP, 1);
        end
        idle(60);
        check_level("up_held", 3'b010);
        btn_up = 1'b0;
        idle(30);
        check_level("up_released", 3'b000);

        // SEL and UP together: SEL wins the press, UP still repeats.
        base = cyc;
        btn_sel = 1'b1;
        btn_up  = 1'b1;
        expect_pulse(base + LAT, 0);
        expect_pulse(base + LAT + HOLD, 1);
        idle(10);
        btn_sel = 1'b0;
        idle(15);
        btn_up = 1'b0;
        idle(30);
        check_level("selup_released", 3'b000);

        // UP held, DOWN joins: DOWN press only, no repeats during conflict.
        base = cyc;
        btn_up = 1'b1;
        expect_pulse(base + LAT, 1);
        idle(10);
        btn_down = 1'b1;
        expect_pulse(base + 10 + LAT, 2);
        idle(40);
        check_level("both_held", 3'b110);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(40);
        check_level("both_released", 3'b000);

        // Reset in the middle of DOWN hold, button kept pressed across it.
        base = cyc;
        btn_down = 1'b1;
        expect_pulse(base + LAT, 2);
        idle(15);
        check_level("down_held", 3'b100);
        rst = 1'b1;
        #1;
        check_level("rst_async_level", 3'b000);
        check_quiet("rst_async_pulses");
        idle(3);
        rst  = 1'b0;
        base = cyc;
        expect_pulse(base + LAT, 2);
        idle(12);
        btn_down = 1'b0;
        idle(30);
        check_level("final_level", 3'b000);

        // Every expected pulse must have been seen.
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected pulses never seen, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
